// File: rtl/dm_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_access_unit : data-memory access stage, one load/store per start pulse,  |
// | req/ack memory port, load extraction/extension into rdata (MDR).            |
// | Optional macro DM_ALIGN_CHECK_EN rejects illegal byte-enable patterns.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dm_access_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        DMWr,
    input  logic [3:0]  be,
    input  logic        ue,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam int              c_CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              c_TO_EN    = (TIMEOUT_CYC != 0);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_we;
    logic            r_ue;
    logic [3:0]      r_be;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_be_ok;
    logic            w_timeout;
    logic [1:0]      w_k;
    logic [2:0]      w_n;
    logic            w_found;
    logic [31:0]     w_shift;
    logic [31:0]     w_load;

`ifdef DM_ALIGN_CHECK_EN
    always_comb begin
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
            default:                   w_be_ok = 1'b0;
        endcase
    end
`else
    assign w_be_ok = 1'b1;
`endif

    assign w_timeout = c_TO_EN && (r_cnt == c_CNT_LAST);

    // Lowest enabled lane picks the shift, lane count picks the width.
    always_comb begin
        w_k     = 2'd0;
        w_n     = 3'd0;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_n = w_n + 3'd1;
                if (!w_found) begin
                    w_k     = 2'(i);
                    w_found = 1'b1;
                end
            end
        end
        w_shift = mem_rdata >> {w_k, 3'b000};
        case (w_n)
            3'd1:       w_load = r_ue ? {24'b0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
            3'd2:       w_load = r_ue ? {16'b0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
            3'd3, 3'd4: w_load = w_shift;
            default:    w_load = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_ue    <= 1'b0;
            r_be    <= 4'b0;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_rdata <= 32'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_err <= 1'b0;
                    if (start) begin
                        r_we    <= DMWr;
                        r_ue    <= ue;
                        r_be    <= be;
                        r_addr  <= {addr[31:2], 2'b00};
                        r_wdata <= wdata << {addr[1:0], 3'b000};
                        r_cnt   <= '0;
                        if (w_be_ok) begin
                            r_state <= c_REQ;
                        end else begin
                            r_state <= c_DONE;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An ack on the final counted cycle still wins over the timeout.
                    if (mem_ack) begin
                        r_state <= c_DONE;
                        r_err   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_DONE;
                        r_err   <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state == c_REQ);
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = mem_req ? r_addr  : 32'b0;
    assign mem_be    = mem_req ? r_be    : 4'b0;
    assign mem_wdata = mem_req ? r_wdata : 32'b0;
    assign rdata     = r_rdata;
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign err       = done & r_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dm_access_unit : table vectors, corner sequences and random accesses     |
// | against a behavioural load/store model.                                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        DMWr;
    logic [3:0]  be;
    logic        ue;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rdata = 32'b0;

    always #5 clk = ~clk;

    dm_access_unit #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .DMWr(DMWr), .be(be), .ue(ue),
        .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rdata(rdata), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        logic [31:0] a;
        logic [3:0]  b;
        logic        u;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference load: select the lowest enabled byte, keep popcount bytes, extend.
    function automatic logic [31:0] ref_load(input logic [3:0] b, input logic u, input logic [31:0] word);
        int k = -1;
        int n = 0;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                n++;
                if (k < 0) k = i;
            end
        end
        if (n == 0) return 32'd0;
        v = word >> (8 * k);
        if (n == 1) begin
            v = v % 256;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic access(input logic [31:0] a, input logic [3:0] b, input logic u,
                          input logic w, input logic [31:0] wd, input int delay,
                          input logic [31:0] word, input logic poke);
        logic [31:0] shifted;
        shifted = wd << (8 * a[1:0]);
        start = 1'b1; addr = a; be = b; ue = u; DMWr = w; wdata = wd;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= delay; c++) begin
            chk("req_high", {31'b0, mem_req}, 32'd1);
            chk("req_addr", mem_addr, {a[31:2], 2'b00});
            chk("req_be", {28'b0, mem_be}, {28'b0, b});
            chk("req_we", {31'b0, mem_we}, {31'b0, w});
            chk("req_nodone", {31'b0, done}, 32'd0);
            if (w) begin
                for (int l = 0; l < 4; l++)
                    if (b[l]) chk("req_wlane", {24'b0, mem_wdata[8*l +: 8]}, {24'b0, shifted[8*l +: 8]});
            end
            if (poke && c == 2) begin
                start = 1'b1; addr = ~a; be = 4'b1111; DMWr = ~w;
            end else begin
                start = 1'b0;
            end
            if (c == delay) begin
                mem_ack = 1'b1;
                mem_rdata = word;
            end
            @(negedge clk);
            start = 1'b0;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
        end
        if (!w) exp_rdata = ref_load(b, u, word);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_err", {31'b0, err}, 32'd0);
        chk("done_noreq", {31'b0, mem_req}, 32'd0);
        chk("rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_req", {31'b0, mem_req}, 32'd0);
    endtask

    vec_t vecs[7];
    logic [3:0] legal_be[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        int cyc;
        logic [3:0] rb;
        vecs[0] = '{32'h0000_1003, 4'b1000, 1'b0, 32'h80AA_BBCC, 32'hFFFF_FF80};
        vecs[1] = '{32'h0000_2002, 4'b1100, 1'b1, 32'h8001_1234, 32'h0000_8001};
        vecs[2] = '{32'h0000_2002, 4'b1100, 1'b0, 32'h8001_1234, 32'hFFFF_8001};
        vecs[3] = '{32'h0000_3000, 4'b0001, 1'b0, 32'h1234_5678, 32'h0000_0078};
        vecs[4] = '{32'h0000_3001, 4'b0010, 1'b0, 32'h0000_F100, 32'hFFFF_FFF1};
        vecs[5] = '{32'h0000_4000, 4'b1111, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[6] = '{32'h0000_5000, 4'b0011, 1'b1, 32'hCAFE_8765, 32'h0000_8765};

        rst = 1'b1; start = 1'b0; DMWr = 1'b0; be = 4'b0; ue = 1'b0;
        addr = 32'b0; wdata = 32'b0; mem_rdata = 32'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_busy", {31'b0, busy}, 32'd0);
        chk("stray_ack_done", {31'b0, done}, 32'd0);
        chk("stray_ack_rdata", rdata, 32'd0);

        for (int i = 0; i < 7; i++) begin
            access(vecs[i].a, vecs[i].b, vecs[i].u, 1'b0, 32'b0, i % 3, vecs[i].word, 1'b0);
            chk("vec_rdata", rdata, vecs[i].exp);
        end

        // Half store to upper lanes, then word store with delayed ack and a stray start.
        access(32'h0000_6002, 4'b1100, 1'b0, 1'b1, 32'h0000_BEEF, 0, 32'b0, 1'b0);
        access(32'h0000_7000, 4'b1111, 1'b0, 1'b1, 32'h1357_9BDF, 5, 32'b0, 1'b1);
        // Ack on the last cycle before timeout must complete normally.
        access(32'h0000_7004, 4'b1111, 1'b0, 1'b0, 32'b0, 15, 32'hA5A5_0F0F, 1'b0);

        // Timeout: no ack at all.
        start = 1'b1; addr = 32'h0000_8000; be = 4'b1111; DMWr = 1'b0; ue = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycle", cyc, 17);
        chk("timeout_err", {31'b0, err}, 32'd1);
        chk("timeout_rdata", rdata, exp_rdata);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_busy", {31'b0, busy}, 32'd0);
        chk("late_ack_done", {31'b0, done}, 32'd0);
        chk("late_ack_rdata", rdata, exp_rdata);

        // Reset in the middle of a request.
        start = 1'b1; addr = 32'h0000_9000; be = 4'b1111; DMWr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("prerst_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'b0;
        chk("midrst_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("postrst_done", {31'b0, done}, 32'd0);
        chk("postrst_rdata", rdata, 32'd0);

`ifdef DM_ALIGN_CHECK_EN
        start = 1'b1; addr = 32'h0000_A000; be = 4'b0101; DMWr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("align_done", {31'b0, done}, 32'd1);
        chk("align_err", {31'b0, err}, 32'd1);
        chk("align_req", {31'b0, mem_req}, 32'd0);
        chk("align_rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("align_idle", {31'b0, busy}, 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef DM_ALIGN_CHECK_EN
            rb = legal_be[$urandom_range(0, 6)];
`else
            rb = (i % 2 == 0) ? legal_be[$urandom_range(0, 6)] : 4'($urandom);
`endif
            access($urandom, rb, 1'($urandom), 1'($urandom), $urandom,
                   $urandom_range(0, 6), $urandom, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
